// File: rtl/cordic_vec_engine.sv
// Iterative CORDIC vectoring engine: atan2(Y,X) and magnitude of a signed pair, one micro-rotation per cycle.
// Define CORDIC_GAIN_COMP_EN to scale MAG by ~1/K (0.6073); otherwise MAG is the raw CORDIC-gained magnitude.
module cordic_vec_engine #(
    parameter int IN_W = 8,
    parameter int ITER = 14,
    parameter int FRAC = 12
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] X_IN,
    input  logic signed [IN_W-1:0] Y_IN,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [FRAC+2:0] ANGLE,
    output logic [IN_W+1:0]        MAG
);
    localparam int W  = IN_W + FRAC + 3;
    localparam int ZW = FRAC + 3;
    localparam int CW = $clog2(ITER);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ROTATE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic signed [ZW-1:0] HALF_PI = ZW'($rtoi(1.5707963267948966 * (2.0 ** FRAC) + 0.5));

    function automatic logic [ZW-1:0] atan_fix(input int i);
        real r;
        r = $atan(1.0 / (2.0 ** i)) * (2.0 ** FRAC);
        return ZW'($rtoi(r + 0.5));
    endfunction

    logic [ITER-1:0][ZW-1:0] atan_tab;
    for (genvar g = 0; g < ITER; g++) begin : g_tab
        localparam logic [ZW-1:0] A = atan_fix(g);
        assign atan_tab[g] = A;
    end

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic signed [W-1:0]    x, y, x_nxt, y_nxt, xsh, ysh, xs, ys;
    logic signed [ZW-1:0]   z, z_nxt;
    logic                   zero_in;
    logic [IN_W+1:0]        mag_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign xs = {{3{X_IN[IN_W-1]}}, X_IN, {FRAC{1'b0}}};
    assign ys = {{3{Y_IN[IN_W-1]}}, Y_IN, {FRAC{1'b0}}};

    // Rotation direction driven by the sign of y, all terms from pre-update values.
    assign xsh   = x >>> cnt;
    assign ysh   = y >>> cnt;
    assign x_nxt = !y[W-1] ? x + ysh : x - ysh;
    assign y_nxt = !y[W-1] ? y - xsh : y + xsh;
    assign z_nxt = !y[W-1] ? z + $signed(atan_tab[cnt]) : z - $signed(atan_tab[cnt]);

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [W+9:0] GAIN = (W+10)'(622);
    localparam logic [W+9:0] RND  = (W+10)'(1) << (FRAC + 9);
    logic [W+9:0] prod;
    logic         unused_prod;
    // x is non-negative after the final iteration, so an unsigned product is safe.
    assign prod        = {10'b0, x_nxt} * GAIN + RND;
    assign mag_nxt     = prod[FRAC+10 +: IN_W+2];
    assign unused_prod = ^{prod[FRAC+9:0], prod[W+9:IN_W+FRAC+12]};
`else
    assign mag_nxt = x_nxt[FRAC +: IN_W+2];
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            zero_in <= 1'b0;
            ANGLE   <= '0;
            MAG     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cnt     <= '0;
                    zero_in <= (X_IN == '0) && (Y_IN == '0);
                    state   <= ROTATE;
                    // Fold the left half-plane into the right so the iterations converge.
                    if (!X_IN[IN_W-1]) begin
                        x <= xs;
                        y <= ys;
                        z <= '0;
                    end else if (!Y_IN[IN_W-1]) begin
                        x <= ys;
                        y <= -xs;
                        z <= HALF_PI;
                    end else begin
                        x <= -ys;
                        y <= xs;
                        z <= -HALF_PI;
                    end
                end
                ROTATE: begin
                    x   <= x_nxt;
                    y   <= y_nxt;
                    z   <= z_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        // A zero vector would otherwise accumulate the whole atan table.
                        ANGLE <= zero_in ? '0 : z_nxt;
                        MAG   <= mag_nxt;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vec_engine.sv
// Directed-vector bench for cordic_vec_engine (IN_W=8, ITER=14, FRAC=12); honours CORDIC_GAIN_COMP_EN.
module tb_cordic_vec_engine;
    localparam int IN_W = 8;
    localparam int ITER = 14;
    localparam int FRAC = 12;

    logic                   CLK = 1'b0;
    logic                   reset, in_valid, out_ready, in_ready, out_valid;
    logic signed [IN_W-1:0] X_IN, Y_IN;
    logic signed [FRAC+2:0] ANGLE;
    logic [IN_W+1:0]        MAG;

    int checks   = 0;
    int failures = 0;

    cordic_vec_engine #(.IN_W(IN_W), .ITER(ITER), .FRAC(FRAC)) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .X_IN(X_IN), .Y_IN(Y_IN), .out_valid(out_valid), .out_ready(out_ready),
        .ANGLE(ANGLE), .MAG(MAG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int    x;
        int    y;
        int    ang;
        int    mag_raw;
        int    mag_comp;
        int    hold;
        string name;
    } vec_t;

    task automatic check(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    function automatic int pick_mag(input vec_t v);
`ifdef CORDIC_GAIN_COMP_EN
        return v.mag_comp;
`else
        return v.mag_raw;
`endif
    endfunction

    // Accept one pair, measure latency (accept edge counted as edge 1), check results, optionally hold, then drain.
    task automatic apply(input vec_t v);
        int n;
        int a0, m0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check({v.name, "_ready"}, int'(in_ready), 1, 0);
        @(negedge CLK);
        X_IN = IN_W'(v.x);
        Y_IN = IN_W'(v.y);
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        X_IN = 8'sd77;
        Y_IN = -8'sd33;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check({v.name, "_latency"}, n, ITER + 1, 0);
        check({v.name, "_angle"}, int'(ANGLE), v.ang, 4);
        check({v.name, "_mag"}, int'(MAG), pick_mag(v), 1);
        a0 = int'(ANGLE);
        m0 = int'(MAG);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge CLK);
            #1;
            check({v.name, "_hold_angle"}, int'(ANGLE), a0, 0);
            check({v.name, "_hold_mag"}, int'(MAG), m0, 0);
            check({v.name, "_hold_in_ready"}, int'(in_ready), 0, 0);
            check({v.name, "_hold_out_valid"}, int'(out_valid), 1, 0);
        end
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        check({v.name, "_drain_in_ready"}, int'(in_ready), 1, 0);
        check({v.name, "_drain_out_valid"}, int'(out_valid), 0, 0);
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   seen;
        int   acc[$];

        tbl[0] = '{x: 100,  y: 0,    ang: 0,     mag_raw: 164, mag_comp: 100, hold: 0, name: "p100_0"};
        tbl[1] = '{x: 0,    y: 50,   ang: 6434,  mag_raw: 82,  mag_comp: 50,  hold: 0, name: "p0_50"};
        tbl[2] = '{x: -100, y: 0,    ang: 12868, mag_raw: 164, mag_comp: 100, hold: 0, name: "m100_0"};
        tbl[3] = '{x: -128, y: -128, ang: -9651, mag_raw: 298, mag_comp: 181, hold: 5, name: "m128_m128"};
        tbl[4] = '{x: 0,    y: 0,    ang: 0,     mag_raw: 0,   mag_comp: 0,   hold: 0, name: "zero"};
        tbl[5] = '{x: 30,   y: 40,   ang: 3798,  mag_raw: 82,  mag_comp: 50,  hold: 0, name: "p30_40"};
        tbl[6] = '{x: 0,    y: -64,  ang: -6434, mag_raw: 105, mag_comp: 64,  hold: 0, name: "p0_m64"};
        tbl[7] = '{x: -3,   y: 4,    ang: 9070,  mag_raw: 8,   mag_comp: 5,   hold: 0, name: "m3_4"};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        X_IN = '0;
        Y_IN = '0;
        #12;
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_angle", int'(ANGLE), 0, 0);
        check("rst_mag", int'(MAG), 0, 0);
        @(negedge CLK);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) apply(tbl[i]);

        // Reset in the middle of iteration 6 must discard the operation.
        @(negedge CLK);
        X_IN = 8'sd100;
        Y_IN = 8'sd0;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge CLK);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0, 0);
        check("midrst_in_ready", int'(in_ready), 1, 0);
        check("midrst_angle", int'(ANGLE), 0, 0);
        @(negedge CLK);
        reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge CLK);
            if (out_valid) seen++;
        end
        check("midrst_no_out_valid", seen, 0, 0);
        v = tbl[5];
        v.name = "post_rst_p30_40";
        apply(v);

        // Back-to-back operation: one acceptance every ITER+2 cycles.
        @(negedge CLK);
        X_IN = 8'sd20;
        Y_IN = 8'sd10;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (in_ready) acc.push_back(c);
            @(negedge CLK);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("tput_accept_count", acc.size(), 4, 0);
        for (int k = 1; k < acc.size(); k++)
            check("tput_interval", acc[k] - acc[k-1], ITER + 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
